// File: rtl/exe_operand_stage_pkg.sv
// Shared constants for the ID/EXE operand stage.
//  - Default datapath widths.
//  - ALU operation codes (EXE_ALU_*). These are the values driven on alu_oper.
//  - Operand-select encodings for id_a_sel / id_b_sel.
package exe_operand_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int OPER_W     = 4;
  localparam int REG_ADDR_W = 5;

  // ALU operation codes
  localparam logic [3:0] EXE_ALU_AND = 4'd0;
  localparam logic [3:0] EXE_ALU_OR  = 4'd1;
  localparam logic [3:0] EXE_ALU_ADD = 4'd2;
  localparam logic [3:0] EXE_ALU_XOR = 4'd3;
  localparam logic [3:0] EXE_ALU_SLL = 4'd4;
  localparam logic [3:0] EXE_ALU_SRL = 4'd5;
  localparam logic [3:0] EXE_ALU_SUB = 4'd6;
  localparam logic [3:0] EXE_ALU_SLT = 4'd7;
  localparam logic [3:0] EXE_ALU_SRA = 4'd8;
  localparam logic [3:0] EXE_ALU_LUI = 4'd9;
  localparam logic [3:0] EXE_ALU_NOR = 4'd12;

  // Operand A source
  localparam logic [1:0] ASEL_RS    = 2'd0;  // forwarded rs
  localparam logic [1:0] ASEL_SHAMT = 2'd1;  // instruction shamt field
  localparam logic [1:0] ASEL_RS5   = 2'd2;  // low 5 bits of forwarded rs (variable shifts)

  // Operand B source
  localparam logic BSEL_RT  = 1'b0;          // forwarded rt
  localparam logic BSEL_IMM = 1'b1;          // extended immediate

endpackage

// File: rtl/exe_operand_stage_if.sv
// Bus between the decode/forwarding side and the EXE operand stage.
//  master: ID fields, stall/flush control, MEM/WB forwarding sources (drives);
//          ALU operands, passed-through control, load_use_stall (receives).
//  slave : the operand stage itself, mirror directions.
interface exe_operand_stage_if
  import exe_operand_stage_pkg::*;
#(
  parameter int DATA_W     = exe_operand_stage_pkg::DATA_W,
  parameter int OPER_W     = exe_operand_stage_pkg::OPER_W,
  parameter int REG_ADDR_W = exe_operand_stage_pkg::REG_ADDR_W
);
  // ID side
  logic                  id_valid;
  logic [OPER_W-1:0]     id_oper;
  logic                  id_sign;
  logic [REG_ADDR_W-1:0] id_rs_addr;
  logic [REG_ADDR_W-1:0] id_rt_addr;
  logic                  id_rs_used;
  logic                  id_rt_used;
  logic [DATA_W-1:0]     id_rs_data;
  logic [DATA_W-1:0]     id_rt_data;
  logic [15:0]           id_imm;
  logic                  id_imm_sext;
  logic [4:0]            id_shamt;
  logic [1:0]            id_a_sel;
  logic                  id_b_sel;
  logic [REG_ADDR_W-1:0] id_wb_addr;
  logic                  id_wb_en;
  logic                  id_mem_ren;
  // pipeline control
  logic                  exe_stall;
  logic                  exe_flush;
  // forwarding sources
  logic                  mem_fwd_en;
  logic [REG_ADDR_W-1:0] mem_fwd_addr;
  logic [DATA_W-1:0]     mem_fwd_data;
  logic                  wb_fwd_en;
  logic [REG_ADDR_W-1:0] wb_fwd_addr;
  logic [DATA_W-1:0]     wb_fwd_data;
  // stage outputs
  logic                  exe_valid;
  logic [DATA_W-1:0]     alu_a;
  logic [DATA_W-1:0]     alu_b;
  logic [OPER_W-1:0]     alu_oper;
  logic                  alu_sign;
  logic [DATA_W-1:0]     exe_store_data;
  logic [REG_ADDR_W-1:0] exe_wb_addr;
  logic                  exe_wb_en;
  logic                  exe_mem_ren;
  logic                  load_use_stall;

  modport master (
    output id_valid, id_oper, id_sign, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
           id_rs_data, id_rt_data, id_imm, id_imm_sext, id_shamt, id_a_sel, id_b_sel,
           id_wb_addr, id_wb_en, id_mem_ren, exe_stall, exe_flush,
           mem_fwd_en, mem_fwd_addr, mem_fwd_data, wb_fwd_en, wb_fwd_addr, wb_fwd_data,
    input  exe_valid, alu_a, alu_b, alu_oper, alu_sign, exe_store_data,
           exe_wb_addr, exe_wb_en, exe_mem_ren, load_use_stall
  );

  modport slave (
    input  id_valid, id_oper, id_sign, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
           id_rs_data, id_rt_data, id_imm, id_imm_sext, id_shamt, id_a_sel, id_b_sel,
           id_wb_addr, id_wb_en, id_mem_ren, exe_stall, exe_flush,
           mem_fwd_en, mem_fwd_addr, mem_fwd_data, wb_fwd_en, wb_fwd_addr, wb_fwd_data,
    output exe_valid, alu_a, alu_b, alu_oper, alu_sign, exe_store_data,
           exe_wb_addr, exe_wb_en, exe_mem_ren, load_use_stall
  );

endinterface

// File: rtl/exe_operand_stage_fwd_mux.sv
// Forwarding mux for one source register.
//  addr/reg_data        : registered source address and register-file value
//  mem_en/addr/data     : MEM-stage result (highest priority)
//  wb_en/addr/data      : WB-stage result
//  data                 : resolved operand value
// Register 0 is hard-wired to zero, so a write to it is never forwarded.
module exe_operand_stage_fwd_mux #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]     reg_data,
  input  logic                  mem_en,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic [DATA_W-1:0]     data
);

  logic addr_nz;
  assign addr_nz = (addr != '0);

  always_comb begin
    data = reg_data;
    if (addr_nz && mem_en && (mem_addr == addr)) begin
      data = mem_data;
    end else if (addr_nz && wb_en && (wb_addr == addr)) begin
      data = wb_data;
    end
  end

endmodule

// File: rtl/exe_operand_stage.sv
// ID/EXE operand stage.
//  clk, rst : clock and synchronous active-high reset
//  bus      : slave side of exe_operand_stage_if (ID fields, stall/flush,
//             MEM/WB forwarding in; ALU operands, control, load_use_stall out)
// One register bank holds the decoded instruction; operands are resolved
// combinationally from it so forwarding sees the latest MEM/WB results.
module exe_operand_stage
  import exe_operand_stage_pkg::*;
#(
  parameter int DATA_W     = exe_operand_stage_pkg::DATA_W,
  parameter int OPER_W     = exe_operand_stage_pkg::OPER_W,
  parameter int REG_ADDR_W = exe_operand_stage_pkg::REG_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  exe_operand_stage_if.slave  bus
);

  typedef struct packed {
    logic                  valid;
    logic [OPER_W-1:0]     oper;
    logic                  sign;
    logic [REG_ADDR_W-1:0] rs_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [15:0]           imm;
    logic                  imm_sext;
    logic [4:0]            shamt;
    logic [1:0]            a_sel;
    logic                  b_sel;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic                  wb_en;
    logic                  mem_ren;
  } stage_t;

  // Bubble and reset contents are the same: an ADD of zeros with no side effects.
  function automatic stage_t bubble();
    stage_t s;
    s      = '0;
    s.oper = OPER_W'(EXE_ALU_ADD);
    return s;
  endfunction

  stage_t            stage_reg;
  stage_t            stage_next;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;
  logic              load_use_hit;

  exe_operand_stage_fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
    .addr(stage_reg.rs_addr), .reg_data(stage_reg.rs_data),
    .mem_en(bus.mem_fwd_en), .mem_addr(bus.mem_fwd_addr), .mem_data(bus.mem_fwd_data),
    .wb_en(bus.wb_fwd_en), .wb_addr(bus.wb_fwd_addr), .wb_data(bus.wb_fwd_data),
    .data(fwd_rs)
  );

  exe_operand_stage_fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
    .addr(stage_reg.rt_addr), .reg_data(stage_reg.rt_data),
    .mem_en(bus.mem_fwd_en), .mem_addr(bus.mem_fwd_addr), .mem_data(bus.mem_fwd_data),
    .wb_en(bus.wb_fwd_en), .wb_addr(bus.wb_fwd_addr), .wb_data(bus.wb_fwd_data),
    .data(fwd_rt)
  );

  // A load in EXE whose destination the ID instruction reads: its data only
  // exists once the load reaches MEM, so ID waits one cycle behind a bubble.
  assign load_use_hit = stage_reg.valid && stage_reg.mem_ren && stage_reg.wb_en &&
                        (stage_reg.wb_addr != '0) && bus.id_valid &&
                        ((bus.id_rs_used && (bus.id_rs_addr == stage_reg.wb_addr)) ||
                         (bus.id_rt_used && (bus.id_rt_addr == stage_reg.wb_addr)));

  assign bus.load_use_stall = load_use_hit && !bus.exe_flush;

  always_comb begin
    stage_next = bubble();
    if (bus.exe_flush) begin
      stage_next = bubble();
    end else if (bus.exe_stall) begin
      // Hold, but latch the forwarded sources: a result retiring from WB
      // during the stall would otherwise vanish before we consume it.
      stage_next         = stage_reg;
      stage_next.rs_data = fwd_rs;
      stage_next.rt_data = fwd_rt;
    end else if (load_use_hit || !bus.id_valid) begin
      stage_next = bubble();
    end else begin
      stage_next.valid    = 1'b1;
      stage_next.oper     = bus.id_oper;
      stage_next.sign     = bus.id_sign;
      stage_next.rs_addr  = bus.id_rs_addr;
      stage_next.rt_addr  = bus.id_rt_addr;
      stage_next.rs_data  = bus.id_rs_data;
      stage_next.rt_data  = bus.id_rt_data;
      stage_next.imm      = bus.id_imm;
      stage_next.imm_sext = bus.id_imm_sext;
      stage_next.shamt    = bus.id_shamt;
      stage_next.a_sel    = bus.id_a_sel;
      stage_next.b_sel    = bus.id_b_sel;
      stage_next.wb_addr  = bus.id_wb_addr;
      stage_next.wb_en    = bus.id_wb_en;
      stage_next.mem_ren  = bus.id_mem_ren;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_reg <= bubble();
    end else begin
      stage_reg <= stage_next;
    end
  end

  // Operand A; shift amounts are masked to 5 bits because the ALU shifts by all of a.
  always_comb begin
    bus.alu_a = fwd_rs;
    case (stage_reg.a_sel)
      ASEL_SHAMT: bus.alu_a = {{(DATA_W-5){1'b0}}, stage_reg.shamt};
      ASEL_RS5:   bus.alu_a = {{(DATA_W-5){1'b0}}, fwd_rs[4:0]};
      default:    bus.alu_a = fwd_rs;
    endcase
  end

  assign bus.alu_b = (stage_reg.b_sel == BSEL_IMM)
                   ? {{(DATA_W-16){stage_reg.imm_sext & stage_reg.imm[15]}}, stage_reg.imm}
                   : fwd_rt;

  assign bus.exe_valid      = stage_reg.valid;
  assign bus.alu_oper       = stage_reg.oper;
  assign bus.alu_sign       = stage_reg.sign;
  assign bus.exe_store_data = fwd_rt;
  assign bus.exe_wb_addr    = stage_reg.wb_addr;
  assign bus.exe_wb_en      = stage_reg.wb_en;
  assign bus.exe_mem_ren    = stage_reg.mem_ren;

endmodule

// File: tb/tb_exe_operand_stage.sv
module tb_exe_operand_stage;
  import exe_operand_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_operand_stage_if bus ();

  exe_operand_stage dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%08h", name, act);
    end
  endtask

  typedef struct {
    logic [3:0]  oper;
    logic        sign;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic [15:0] imm;
    logic        sext;
    logic [4:0]  shamt;
    logic [1:0]  asel;
    logic        bsel;
    logic        mem_en;
    logic [4:0]  mem_a;
    logic [31:0] mem_d;
    logic        wb_en;
    logic [4:0]  wb_a;
    logic [31:0] wb_d;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] es;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
    logic [3:0]  oper;
    logic        sign;
  } exp_t;

  vec_t vecs[11];
  exp_t sbq[$];

  task automatic idle();
    bus.id_valid = 0; bus.id_oper = 0; bus.id_sign = 0;
    bus.id_rs_addr = 0; bus.id_rt_addr = 0; bus.id_rs_used = 0; bus.id_rt_used = 0;
    bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0; bus.id_imm_sext = 0;
    bus.id_shamt = 0; bus.id_a_sel = 0; bus.id_b_sel = 0;
    bus.id_wb_addr = 0; bus.id_wb_en = 0; bus.id_mem_ren = 0;
    bus.exe_stall = 0; bus.exe_flush = 0;
    bus.mem_fwd_en = 0; bus.mem_fwd_addr = 0; bus.mem_fwd_data = 0;
    bus.wb_fwd_en = 0; bus.wb_fwd_addr = 0; bus.wb_fwd_data = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    // order: oper sign rs rt rs_d rt_d imm sext shamt asel bsel
    //        mem_en mem_a mem_d wb_en wb_a wb_d | exp a, exp b, exp store
    vecs[0]  = '{EXE_ALU_ADD, 1, 3, 0, 32'h10, 0, 16'hFFFF, 1, 0, ASEL_RS, BSEL_IMM,
                 0, 0, 0, 0, 0, 0, 32'h10, 32'hFFFF_FFFF, 0};
    vecs[1]  = '{EXE_ALU_ADD, 1, 5, 6, 32'h1, 32'h22, 0, 0, 0, ASEL_RS, BSEL_RT,
                 1, 5, 32'h7, 1, 5, 32'h9, 32'h7, 32'h22, 32'h22};
    vecs[2]  = '{EXE_ALU_ADD, 1, 5, 6, 32'h1, 32'h22, 0, 0, 0, ASEL_RS, BSEL_RT,
                 0, 5, 32'h7, 1, 5, 32'h9, 32'h9, 32'h22, 32'h22};
    vecs[3]  = '{EXE_ALU_ADD, 0, 0, 6, 0, 32'h22, 0, 0, 0, ASEL_RS, BSEL_RT,
                 1, 0, 32'h5, 1, 0, 32'h6, 0, 32'h22, 32'h22};
    vecs[4]  = '{EXE_ALU_SUB, 1, 1, 7, 32'h3, 32'h1, 0, 0, 0, ASEL_RS, BSEL_RT,
                 1, 8, 32'h33, 1, 7, 32'h44, 32'h3, 32'h44, 32'h44};
    vecs[5]  = '{EXE_ALU_SRL, 0, 9, 10, 32'h23, 32'h1000, 0, 0, 0, ASEL_RS5, BSEL_RT,
                 0, 0, 0, 0, 0, 0, 32'h3, 32'h1000, 32'h1000};
    vecs[6]  = '{EXE_ALU_SLL, 0, 11, 4, 32'hFFFF, 32'h80, 0, 0, 31, ASEL_SHAMT, BSEL_RT,
                 0, 0, 0, 0, 0, 0, 32'd31, 32'h80, 32'h80};
    vecs[7]  = '{EXE_ALU_LUI, 0, 0, 0, 0, 0, 16'h8001, 0, 0, ASEL_RS, BSEL_IMM,
                 0, 0, 0, 0, 0, 0, 0, 32'h0000_8001, 0};
    vecs[8]  = '{EXE_ALU_OR, 0, 1, 0, 32'hDEAD_BEEF, 0, 16'hF0F0, 0, 0, ASEL_RS, BSEL_IMM,
                 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'h0000_F0F0, 0};
    vecs[9]  = '{EXE_ALU_AND, 1, 0, 2, 0, 32'h5, 0, 0, 0, ASEL_RS, BSEL_RT,
                 1, 2, 32'h11, 1, 2, 32'h22, 0, 32'h11, 32'h11};
    vecs[10] = '{EXE_ALU_ADD, 1, 12, 0, 32'h1, 0, 16'h7FFF, 1, 0, ASEL_RS, BSEL_IMM,
                 1, 13, 32'h6, 1, 12, 32'h5, 32'h5, 32'h0000_7FFF, 0};

    // ---- reset, with a valid instruction presented the whole time
    idle();
    rst = 1;
    bus.id_valid = 1; bus.id_rs_addr = 3; bus.id_rs_data = 32'h77; bus.id_wb_en = 1;
    bus.id_oper = EXE_ALU_SUB;
    @(posedge clk); @(posedge clk); #1;
    chk("rst exe_valid", 32'(bus.exe_valid), 0);
    chk("rst alu_oper", 32'(bus.alu_oper), 32'(EXE_ALU_ADD));
    chk("rst alu_a", bus.alu_a, 0);
    chk("rst alu_b", bus.alu_b, 0);
    chk("rst load_use_stall", 32'(bus.load_use_stall), 0);
    chk("rst exe_wb_en", 32'(bus.exe_wb_en), 0);
    rst = 0;
    idle();

    // ---- table-driven single-instruction vectors through the scoreboard
    for (int i = 0; i < 11; i++) begin
      bus.id_valid = 1; bus.id_oper = vecs[i].oper; bus.id_sign = vecs[i].sign;
      bus.id_rs_addr = vecs[i].rs; bus.id_rt_addr = vecs[i].rt;
      bus.id_rs_used = 1; bus.id_rt_used = 1;
      bus.id_rs_data = vecs[i].rs_d; bus.id_rt_data = vecs[i].rt_d;
      bus.id_imm = vecs[i].imm; bus.id_imm_sext = vecs[i].sext; bus.id_shamt = vecs[i].shamt;
      bus.id_a_sel = vecs[i].asel; bus.id_b_sel = vecs[i].bsel;
      bus.mem_fwd_en = vecs[i].mem_en; bus.mem_fwd_addr = vecs[i].mem_a;
      bus.mem_fwd_data = vecs[i].mem_d;
      bus.wb_fwd_en = vecs[i].wb_en; bus.wb_fwd_addr = vecs[i].wb_a; bus.wb_fwd_data = vecs[i].wb_d;
      sbq.push_back('{vecs[i].ea, vecs[i].eb, vecs[i].es, vecs[i].oper, vecs[i].sign});
      @(posedge clk); #1;
      e = sbq.pop_front();
      $display("vec %0d:", i);
      chk("vec exe_valid", 32'(bus.exe_valid), 1);
      chk("vec alu_a", bus.alu_a, e.a);
      chk("vec alu_b", bus.alu_b, e.b);
      chk("vec store_data", bus.exe_store_data, e.st);
      chk("vec alu_oper", 32'(bus.alu_oper), 32'(e.oper));
      chk("vec alu_sign", 32'(bus.alu_sign), 32'(e.sign));
    end
    idle();

    // ---- load-use: LW $4 in EXE, dependent ADD in ID
    bus.id_valid = 1; bus.id_oper = EXE_ALU_ADD; bus.id_rs_addr = 1; bus.id_rs_used = 1;
    bus.id_rs_data = 32'h100; bus.id_imm = 16'h4; bus.id_imm_sext = 1; bus.id_b_sel = BSEL_IMM;
    bus.id_wb_addr = 4; bus.id_wb_en = 1; bus.id_mem_ren = 1;
    @(posedge clk); #1;
    chk("lw exe_mem_ren", 32'(bus.exe_mem_ren), 1);
    chk("lw exe_wb_addr", 32'(bus.exe_wb_addr), 4);
    idle();
    bus.id_valid = 1; bus.id_oper = EXE_ALU_ADD; bus.id_rs_addr = 4; bus.id_rt_addr = 5;
    bus.id_rs_used = 0; bus.id_rt_used = 0; bus.id_rt_data = 32'h2; bus.id_b_sel = BSEL_RT;
    bus.id_wb_addr = 6; bus.id_wb_en = 1;
    #1 chk("lu unused no stall", 32'(bus.load_use_stall), 0);
    bus.id_rs_used = 1; bus.id_rt_used = 1;
    #1 chk("lu stall", 32'(bus.load_use_stall), 1);
    bus.exe_flush = 1;
    #1 chk("lu stall masked by flush", 32'(bus.load_use_stall), 0);
    bus.exe_flush = 0;
    @(posedge clk); #1;
    chk("lu bubble exe_valid", 32'(bus.exe_valid), 0);
    chk("lu bubble wb_en", 32'(bus.exe_wb_en), 0);
    chk("lu stall released", 32'(bus.load_use_stall), 0);
    @(posedge clk); #1;
    bus.mem_fwd_en = 1; bus.mem_fwd_addr = 4; bus.mem_fwd_data = 32'h55;
    #1;
    chk("lu add exe_valid", 32'(bus.exe_valid), 1);
    chk("lu add alu_a fwd", bus.alu_a, 32'h55);
    chk("lu add alu_b", bus.alu_b, 32'h2);
    idle();

    // ---- stall 3 cycles while WB retires $2=0xAB
    bus.id_valid = 1; bus.id_oper = EXE_ALU_SUB; bus.id_rt_addr = 2; bus.id_rt_used = 1;
    bus.id_rt_data = 32'h1; bus.id_b_sel = BSEL_RT; bus.id_wb_addr = 9; bus.id_wb_en = 1;
    @(posedge clk); #1;
    chk("stall pre alu_b", bus.alu_b, 32'h1);
    bus.exe_stall = 1;
    bus.id_oper = EXE_ALU_OR; bus.id_rt_addr = 3; bus.id_rt_data = 32'h99;
    bus.wb_fwd_en = 1; bus.wb_fwd_addr = 2; bus.wb_fwd_data = 32'hAB;
    @(posedge clk); #1;
    bus.wb_fwd_en = 0; bus.wb_fwd_data = 0;
    @(posedge clk); @(posedge clk); #1;
    bus.exe_stall = 0;
    #1;
    chk("stall alu_b kept", bus.alu_b, 32'hAB);
    chk("stall store_data kept", bus.exe_store_data, 32'hAB);
    chk("stall alu_oper held", 32'(bus.alu_oper), 32'(EXE_ALU_SUB));
    chk("stall exe_valid held", 32'(bus.exe_valid), 1);
    bus.exe_stall = 1; bus.exe_flush = 1;
    @(posedge clk); #1;
    chk("flush+stall exe_valid", 32'(bus.exe_valid), 0);
    chk("flush+stall wb_en", 32'(bus.exe_wb_en), 0);
    chk("flush+stall alu_oper", 32'(bus.alu_oper), 32'(EXE_ALU_ADD));
    idle();

    // ---- reset mid-operation discards the pending instruction
    bus.id_valid = 1; bus.id_oper = EXE_ALU_XOR; bus.id_rs_addr = 7; bus.id_rs_data = 32'h1234;
    bus.id_wb_addr = 7; bus.id_wb_en = 1;
    @(posedge clk); #1;
    chk("midrst pre alu_a", bus.alu_a, 32'h1234);
    rst = 1;
    @(posedge clk); #1;
    chk("midrst exe_valid", 32'(bus.exe_valid), 0);
    chk("midrst alu_a", bus.alu_a, 0);
    chk("midrst exe_wb_en", 32'(bus.exe_wb_en), 0);
    rst = 0;
    idle();
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
